// File: rtl/ddr3_cmd_arbiter_pkg.sv
// Shared command codes, arbiter state encoding and request legality helper
// for the DDR3 user-interface command arbiter.
package ddr3_cmd_arbiter_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_IDLE  = 3'd2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // A request may only compete for the channel with a WRITE/READ command and a non-zero burst
  function automatic logic cmd_is_legal(input logic [2:0] cmd, input logic [9:0] size);
    return ((cmd == CMD_WRITE) || (cmd == CMD_READ)) && (size != 10'd0);
  endfunction

endpackage

// File: rtl/ddr3_cmd_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: returns the first requesting
// port at or after ptr (wrapping modulo NUM_REQ) as one-hot and as an index.
module ddr3_cmd_arbiter_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0]    sum;
  logic [IDX_W-1:0] cand;

  // Walk the ports starting at ptr with wrap-around; the first one requesting wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Shares the single DDR3 UI command/write-data channel among NUM_REQ requesters.
// Port 0 is the preload/init engine; ports 1.. are held off until init_done.
// One burst at a time: the winner owns the channel until its write/read finish
// (or the watchdog fires), then the round-robin pointer moves past it.
module ddr3_cmd_arbiter
  import ddr3_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DDR_WIDTH   = 64,
  parameter int UI_WIDTH    = DDR_WIDTH * 8,
  parameter int ADDR_WIDTH  = 29,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                           ui_clk,
  input  logic                           ui_rst,
  input  logic                           init_done,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [3*NUM_REQ-1:0]           req_cmd,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_addr,
  input  logic [10*NUM_REQ-1:0]          req_size,
  input  logic [UI_WIDTH*NUM_REQ-1:0]    req_wdf_data,
  input  logic [NUM_REQ-1:0]             req_wdf_valid,
  output logic [NUM_REQ-1:0]             req_grant,
  output logic [NUM_REQ-1:0]             req_wdf_rdy,
  output logic [NUM_REQ-1:0]             req_rd_valid,
  output logic [UI_WIDTH-1:0]            req_rd_data,
  output logic [NUM_REQ-1:0]             req_done,
  input  logic                           ddr_rdy,
  input  logic                           ddr_wdf_data_rdy,
  input  logic                           ddr_wr_finish,
  input  logic                           ddr_rd_finish,
  input  logic                           ddr_rd_data_valid,
  input  logic [UI_WIDTH-1:0]            ddr_rd_data,
  output logic [2:0]                     ddr_cmd,
  output logic                           ddr_cmd_valid,
  output logic [ADDR_WIDTH-1:0]          ddr_base_addr,
  output logic [9:0]                     ddr_size,
  output logic [UI_WIDTH-1:0]            ddr_wdf_data,
  output logic                           ddr_wdf_data_valid,
  output logic                           timeout_err
);

  localparam int          IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_REQ - 1);

  arb_state_e state, state_nxt;

  logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]      owner, owner_nxt;
  logic [2:0]            cmd_nxt;
  logic                  cmd_valid_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [9:0]            size_nxt;
  logic [NUM_REQ-1:0]    grant_nxt, done_nxt;
  logic                  timeout_nxt;
  logic [15:0]           wdog, wdog_nxt;

  logic [NUM_REQ-1:0]    legal, unmask, eligible;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [NUM_REQ-1:0]    owner_onehot;
  logic                  finish;
  logic                  busy;

  // Flag ports whose command/size pair is legal; illegal ones never compete
  always_comb begin
    legal = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      legal[p] = cmd_is_legal(req_cmd[3*p +: 3], req_size[10*p +: 10]);
    end
  end

  assign unmask   = {{(NUM_REQ-1){init_done}}, 1'b1};
  assign eligible = req_valid & unmask & legal;

  ddr3_cmd_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (eligible),
    .ptr       (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign busy         = (state == ARB_BUSY);
  assign owner_onehot = NUM_REQ'(1) << owner;
  assign finish       = ((ddr_cmd == CMD_WRITE) && ddr_wr_finish) ||
                        ((ddr_cmd == CMD_READ)  && ddr_rd_finish);

  assign req_wdf_rdy        = (busy && ddr_wdf_data_rdy)  ? owner_onehot : '0;
  assign req_rd_valid       = (busy && ddr_rd_data_valid) ? owner_onehot : '0;
  assign req_rd_data        = ddr_rd_data;
  assign ddr_wdf_data       = req_wdf_data[UI_WIDTH*owner +: UI_WIDTH];
  assign ddr_wdf_data_valid = busy && (ddr_cmd == CMD_WRITE) && req_wdf_valid[owner];

  // Next-state logic: grant from IDLE, hold ownership in BUSY until finish or watchdog expiry
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    cmd_nxt       = ddr_cmd;
    cmd_valid_nxt = 1'b0;
    addr_nxt      = ddr_base_addr;
    size_nxt      = ddr_size;
    grant_nxt     = '0;
    done_nxt      = '0;
    timeout_nxt   = timeout_err;
    wdog_nxt      = wdog;
    case (state)
      ARB_IDLE: begin
        cmd_nxt = CMD_IDLE;
        if (ddr_rdy && pick_any) begin
          owner_nxt     = pick_idx;
          cmd_nxt       = req_cmd[3*pick_idx +: 3];
          addr_nxt      = req_addr[ADDR_WIDTH*pick_idx +: ADDR_WIDTH];
          size_nxt      = req_size[10*pick_idx +: 10];
          cmd_valid_nxt = 1'b1;
          grant_nxt     = pick_onehot;
          wdog_nxt      = '0;
          state_nxt     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (finish || (wdog == WDOG_LIMIT)) begin
          if (!finish) begin
            timeout_nxt = 1'b1;
          end
          done_nxt   = owner_onehot;
          rr_ptr_nxt = (owner == LAST_PORT) ? '0 : owner + IDX_W'(1);
          cmd_nxt    = CMD_IDLE;
          wdog_nxt   = '0;
          state_nxt  = ARB_IDLE;
        end else begin
          wdog_nxt = wdog + 16'd1;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight without a done pulse
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      state         <= ARB_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      ddr_cmd       <= CMD_IDLE;
      ddr_cmd_valid <= 1'b0;
      ddr_base_addr <= '0;
      ddr_size      <= '0;
      req_grant     <= '0;
      req_done      <= '0;
      timeout_err   <= 1'b0;
      wdog          <= '0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      owner         <= owner_nxt;
      ddr_cmd       <= cmd_nxt;
      ddr_cmd_valid <= cmd_valid_nxt;
      ddr_base_addr <= addr_nxt;
      ddr_size      <= size_nxt;
      req_grant     <= grant_nxt;
      req_done      <= done_nxt;
      timeout_err   <= timeout_nxt;
      wdog          <= wdog_nxt;
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Self-checking bench for ddr3_cmd_arbiter: a transaction-level model of the
// arbitration rules is compared against the DUT every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_ddr3_cmd_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int UW = DW * 8;
  localparam int AW = 29;
  localparam int TO = 160;

  logic                ui_clk = 1'b0;
  logic                ui_rst;
  logic                init_done;
  logic [N-1:0]        req_valid;
  logic [3*N-1:0]      req_cmd;
  logic [AW*N-1:0]     req_addr;
  logic [10*N-1:0]     req_size;
  logic [UW*N-1:0]     req_wdf_data;
  logic [N-1:0]        req_wdf_valid;
  logic [N-1:0]        req_grant, req_wdf_rdy, req_rd_valid, req_done;
  logic [UW-1:0]       req_rd_data;
  logic                ddr_rdy, ddr_wdf_data_rdy, ddr_wr_finish, ddr_rd_finish, ddr_rd_data_valid;
  logic [UW-1:0]       ddr_rd_data;
  logic [2:0]          ddr_cmd;
  logic                ddr_cmd_valid;
  logic [AW-1:0]       ddr_base_addr;
  logic [9:0]          ddr_size;
  logic [UW-1:0]       ddr_wdf_data;
  logic                ddr_wdf_data_valid;
  logic                timeout_err;

  always #5 ui_clk = ~ui_clk;

  ddr3_cmd_arbiter #(
    .NUM_REQ(N), .DDR_WIDTH(DW), .UI_WIDTH(UW), .ADDR_WIDTH(AW), .TIMEOUT_CYC(TO)
  ) dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst), .init_done(init_done),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_size(req_size),
    .req_wdf_data(req_wdf_data), .req_wdf_valid(req_wdf_valid),
    .req_grant(req_grant), .req_wdf_rdy(req_wdf_rdy), .req_rd_valid(req_rd_valid),
    .req_rd_data(req_rd_data), .req_done(req_done),
    .ddr_rdy(ddr_rdy), .ddr_wdf_data_rdy(ddr_wdf_data_rdy), .ddr_wr_finish(ddr_wr_finish),
    .ddr_rd_finish(ddr_rd_finish), .ddr_rd_data_valid(ddr_rd_data_valid), .ddr_rd_data(ddr_rd_data),
    .ddr_cmd(ddr_cmd), .ddr_cmd_valid(ddr_cmd_valid), .ddr_base_addr(ddr_base_addr),
    .ddr_size(ddr_size), .ddr_wdf_data(ddr_wdf_data), .ddr_wdf_data_valid(ddr_wdf_data_valid),
    .timeout_err(timeout_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: who owns the channel, pointer, and what the registered outputs must be
  bit        model_live = 0;
  bit        m_busy;
  int        m_owner, m_ptr, m_cmd, m_cnt;
  bit        m_valid, m_terr;
  bit [AW-1:0] m_addr;
  bit [9:0]  m_size;
  bit [N-1:0] m_grant, m_done;

  function automatic bit portEligible(input int p);
    return req_valid[p] && (p == 0 || init_done) &&
           (req_cmd[3*p +: 3] <= 3'd1) && (req_size[10*p +: 10] != 10'd0);
  endfunction

  // Advance the model on each rising edge from the inputs as they stood before the edge
  always @(posedge ui_clk) begin
    bit found;
    bit fin;
    int p;
    if (ui_rst) begin
      model_live = 1; m_busy = 0; m_owner = 0; m_ptr = 0; m_cmd = 2; m_cnt = 0;
      m_valid = 0; m_terr = 0; m_addr = '0; m_size = '0; m_grant = '0; m_done = '0;
    end else begin
      m_valid = 0; m_grant = '0; m_done = '0;
      if (!m_busy) begin
        found = 0;
        if (ddr_rdy) begin
          for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (!found && portEligible(p)) begin
              found = 1; m_busy = 1; m_owner = p; m_cnt = 0; m_valid = 1;
              m_cmd = int'(req_cmd[3*p +: 3]);
              m_addr = req_addr[AW*p +: AW];
              m_size = req_size[10*p +: 10];
              m_grant[p] = 1'b1;
            end
          end
        end
      end else begin
        m_cnt++;
        fin = (m_cmd == 0 && ddr_wr_finish) || (m_cmd == 1 && ddr_rd_finish);
        if (fin || m_cnt == TO) begin
          if (!fin) m_terr = 1;
          m_done[m_owner] = 1'b1;
          m_ptr = (m_owner + 1) % N;
          m_cmd = 2;
          m_busy = 0;
        end
      end
    end
  end

  // Compare every DUT output against the model in the middle of each cycle
  always @(negedge ui_clk) begin
    if (model_live) begin
      checkOutput("ddr_cmd", ddr_cmd, m_cmd);
      checkOutput("ddr_cmd_valid", ddr_cmd_valid, m_valid);
      checkOutput("ddr_base_addr", ddr_base_addr, m_addr);
      checkOutput("ddr_size", ddr_size, m_size);
      checkOutput("req_grant", req_grant, m_grant);
      checkOutput("req_done", req_done, m_done);
      checkOutput("timeout_err", timeout_err, m_terr);
      checkOutput("req_wdf_rdy", req_wdf_rdy, (m_busy && ddr_wdf_data_rdy) ? (N'(1) << m_owner) : '0);
      checkOutput("req_rd_valid", req_rd_valid, (m_busy && ddr_rd_data_valid) ? (N'(1) << m_owner) : '0);
      checkOutput("ddr_wdf_data", ddr_wdf_data, req_wdf_data[UW*m_owner +: UW]);
      checkOutput("ddr_wdf_data_valid", ddr_wdf_data_valid, m_busy && m_cmd == 0 && req_wdf_valid[m_owner]);
      checkOutput("req_rd_data", req_rd_data, ddr_rd_data);
    end
  end

  // Event log of grants, done pulses, strobe spacing and data beats seen on the DUT
  int cyc = 0;
  int grant_q[$];
  int done_q[$];
  int grant_count = 0, done_count = 0, beats = 0;
  int last_grant_cyc = 0, last_done_cyc = 0, last_strobe = -1;
  int rdv_cnt[N];

  function automatic int ohIdx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge ui_clk) cyc++;

  always @(negedge ui_clk) begin
    if (model_live) begin
      if (req_grant != '0) begin grant_q.push_back(ohIdx(req_grant)); grant_count++; last_grant_cyc = cyc; end
      if (req_done != '0) begin done_q.push_back(ohIdx(req_done)); done_count++; last_done_cyc = cyc; end
      if (ddr_cmd_valid) begin
        if (last_strobe >= 0) checkOutput("strobe_gap_ge2", (cyc - last_strobe) >= 2, 1);
        last_strobe = cyc;
      end
      if (ddr_wdf_data_valid && ddr_wdf_data_rdy) beats++;
      for (int i = 0; i < N; i++) if (req_rd_valid[i]) rdv_cnt[i]++;
    end
  end

  task automatic step();
    @(posedge ui_clk);
    #2;
  endtask

  task automatic applyStimulus(input int p, input logic v, input logic [2:0] cmd,
                               input logic [AW-1:0] addr, input logic [9:0] size);
    req_valid[p]          = v;
    req_cmd[3*p +: 3]     = cmd;
    req_addr[AW*p +: AW]  = addr;
    req_size[10*p +: 10]  = size;
  endtask

  task automatic waitGrants(input int target, input string name);
    int b = 0;
    while (grant_count < target && b < 100) begin step(); b++; end
    checkOutput(name, grant_count >= target, 1);
  endtask

  task automatic waitDones(input int target, input int budget, input string name);
    int b = 0;
    while (done_count < target && b < budget) begin step(); b++; end
    checkOutput(name, done_count >= target, 1);
  endtask

  task automatic pulseWrFinish();
    ddr_wr_finish = 1'b1; step(); ddr_wr_finish = 1'b0;
  endtask

  task automatic pulseRdFinish();
    ddr_rd_finish = 1'b1; step(); ddr_rd_finish = 1'b0;
  endtask

  function automatic int grantAt(input int i);
    return (i < grant_q.size()) ? grant_q[i] : -1;
  endfunction

  initial begin
    int g0, d0, b0, q0, gc, r0[N];
    int exp_order[4] = '{0, 1, 2, 0};

    ui_rst = 1'b1; init_done = 1'b0; req_valid = '0; req_cmd = '0; req_addr = '0; req_size = '0;
    req_wdf_valid = '0; ddr_rdy = 1'b0; ddr_wdf_data_rdy = 1'b0; ddr_wr_finish = 1'b0;
    ddr_rd_finish = 1'b0; ddr_rd_data_valid = 1'b0; ddr_rd_data = '0;
    req_wdf_data = {64'hC2C2_0000_2222_0002, 64'hC1C1_0000_1111_0001, 64'hC0C0_0000_0000_0000};
    for (int i = 0; i < N; i++) rdv_cnt[i] = 0;
    repeat (3) step();
    checkOutput("rst_ddr_cmd", ddr_cmd, 3'd2);
    checkOutput("rst_timeout_err", timeout_err, 1'b0);
    checkOutput("rst_grant", req_grant, 3'b000);
    ui_rst = 1'b0;
    step();

    // Scenario 1: only port 0 may win while init_done is low; 150 write beats pass through
    $display("[TB] scenario 1: init masking, 150-beat write");
    ddr_rdy = 1'b1; ddr_wdf_data_rdy = 1'b1;
    applyStimulus(0, 1'b1, 3'd0, 29'h40, 10'd150);
    applyStimulus(1, 1'b1, 3'd1, 29'h80, 10'd4);
    applyStimulus(2, 1'b1, 3'd1, 29'hC0, 10'd4);
    req_wdf_valid[0] = 1'b1;
    g0 = grant_count; d0 = done_count; b0 = beats; q0 = grant_q.size();
    waitGrants(g0 + 1, "t1_grant_seen");
    req_valid[0] = 1'b0;
    for (int b = 0; b < 200 && (beats - b0) < 150; b++) step();
    req_wdf_valid[0] = 1'b0;
    pulseWrFinish();
    waitDones(d0 + 1, 20, "t1_done_seen");
    repeat (4) step();
    checkOutput("t1_beats", beats - b0, 150);
    checkOutput("t1_grant_count", grant_count - g0, 1);
    checkOutput("t1_grant_port", grantAt(q0), 0);
    checkOutput("t1_done_port", done_q[$], 0);
    req_valid = '0;

    // Scenario 2: after reset all three ports contend; order must be 0,1,2,0
    $display("[TB] scenario 2: round-robin order");
    ui_rst = 1'b1; step(); step(); ui_rst = 1'b0;
    init_done = 1'b1;
    applyStimulus(0, 1'b1, 3'd0, 29'h100, 10'd2);
    applyStimulus(1, 1'b1, 3'd0, 29'h200, 10'd2);
    applyStimulus(2, 1'b1, 3'd0, 29'h300, 10'd2);
    g0 = grant_count; d0 = done_count; q0 = grant_q.size();
    for (int t = 0; t < 4; t++) begin
      waitGrants(g0 + t + 1, "t2_grant_seen");
      if (t == 3) req_valid = '0;
      step();
      pulseWrFinish();
      waitDones(d0 + t + 1, 20, "t2_done_seen");
    end
    for (int t = 0; t < 4; t++) checkOutput("t2_grant_order", grantAt(q0 + t), exp_order[t]);
    step();

    // Scenario 3: port 1 READ while ports 0/2 present illegal requests
    $display("[TB] scenario 3: read routing and illegal requests");
    applyStimulus(0, 1'b1, 3'd0, 29'h500, 10'd0);
    applyStimulus(1, 1'b1, 3'd1, 29'h1000, 10'd4);
    applyStimulus(2, 1'b1, 3'd3, 29'h600, 10'd4);
    g0 = grant_count; d0 = done_count; q0 = grant_q.size();
    for (int i = 0; i < N; i++) r0[i] = rdv_cnt[i];
    waitGrants(g0 + 1, "t3_grant_seen");
    req_valid[1] = 1'b0;
    checkOutput("t3_ddr_cmd", ddr_cmd, 3'd1);
    checkOutput("t3_base_addr", ddr_base_addr, 29'h1000);
    checkOutput("t3_size", ddr_size, 10'd4);
    for (int k = 0; k < 4; k++) begin
      ddr_rd_data_valid = 1'b1; ddr_rd_data = 64'hD0D0_0000_0000_0000 | 64'(k);
      step();
    end
    ddr_rd_data_valid = 1'b0;
    pulseRdFinish();
    waitDones(d0 + 1, 20, "t3_done_seen");
    repeat (5) step();
    checkOutput("t3_grant_count", grant_count - g0, 1);
    checkOutput("t3_grant_port", grantAt(q0), 1);
    checkOutput("t3_rd_valid_p1", rdv_cnt[1] - r0[1], 4);
    checkOutput("t3_rd_valid_p0", rdv_cnt[0] - r0[0], 0);
    checkOutput("t3_rd_valid_p2", rdv_cnt[2] - r0[2], 0);
    req_valid = '0;
    step();

    // Scenario 4: a write owner ignores a spurious read finish
    $display("[TB] scenario 4: wrong finish ignored");
    applyStimulus(2, 1'b1, 3'd0, 29'h2000, 10'd8);
    req_wdf_valid[2] = 1'b1;
    g0 = grant_count; d0 = done_count;
    waitGrants(g0 + 1, "t4_grant_seen");
    req_valid[2] = 1'b0;
    pulseRdFinish();
    repeat (3) step();
    checkOutput("t4_no_done", done_count - d0, 0);
    checkOutput("t4_still_write", ddr_cmd, 3'd0);
    pulseWrFinish();
    waitDones(d0 + 1, 20, "t4_done_seen");
    checkOutput("t4_done_port", done_q[$], 2);
    req_wdf_valid[2] = 1'b0;
    step();

    // Scenario 5: watchdog expiry with port 1 waiting behind
    $display("[TB] scenario 5: watchdog");
    applyStimulus(0, 1'b1, 3'd0, 29'h3000, 10'd8);
    applyStimulus(1, 1'b1, 3'd0, 29'h4000, 10'd8);
    g0 = grant_count; d0 = done_count;
    waitGrants(g0 + 1, "t5_grant_seen");
    gc = last_grant_cyc;
    req_valid[0] = 1'b0;
    waitDones(d0 + 1, TO + 40, "t5_timeout_done_seen");
    checkOutput("t5_timeout_err", timeout_err, 1'b1);
    checkOutput("t5_done_port", done_q[$], 0);
    checkOutput("t5_busy_cycles", last_done_cyc - gc, TO);
    waitGrants(g0 + 2, "t5_next_grant_seen");
    checkOutput("t5_next_port", grant_q[$], 1);
    req_valid[1] = 1'b0;
    pulseWrFinish();
    waitDones(d0 + 2, 20, "t5_done2_seen");
    step();

    // Scenario 6: reset in the middle of a transaction
    $display("[TB] scenario 6: reset mid-transaction");
    applyStimulus(2, 1'b1, 3'd0, 29'h5000, 10'd8);
    applyStimulus(0, 1'b1, 3'd0, 29'h6000, 10'd8);
    g0 = grant_count; d0 = done_count;
    waitGrants(g0 + 1, "t6_grant_seen");
    checkOutput("t6_first_port", grant_q[$], 2);
    step();
    ui_rst = 1'b1;
    step();
    checkOutput("t6_rst_cmd", ddr_cmd, 3'd2);
    checkOutput("t6_rst_cmd_valid", ddr_cmd_valid, 1'b0);
    checkOutput("t6_rst_done", req_done, 3'b000);
    checkOutput("t6_rst_timeout_err", timeout_err, 1'b0);
    checkOutput("t6_rst_addr", ddr_base_addr, 29'h0);
    checkOutput("t6_rst_size", ddr_size, 10'd0);
    ui_rst = 1'b0;
    waitGrants(g0 + 2, "t6_regrant_seen");
    checkOutput("t6_port0_first", grant_q[$], 0);
    req_valid[0] = 1'b0;
    pulseWrFinish();
    waitGrants(g0 + 3, "t6_port2_seen");
    checkOutput("t6_port2_next", grant_q[$], 2);
    req_valid[2] = 1'b0;
    pulseWrFinish();
    waitDones(d0 + 2, 20, "t6_done_seen");
    checkOutput("t6_no_abandoned_done", done_count - d0, 2);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
